// File: rtl/zx_pixel_serializer_if.sv
// Video-latch side bundle for zx_pixel_serializer: cell load inputs, border/blank/frame
// controls and the registered RGBI/ACTIVE outputs.
interface zx_pixel_serializer_if;
  logic       CE;
  logic       LD;
  logic       DE;
  logic [7:0] D_PIX;
  logic [7:0] D_ATTR;
  logic [2:0] BORDER;
  logic       BLANK;
  logic       FRAME;
  logic       COL_R;
  logic       COL_G;
  logic       COL_B;
  logic       COL_I;
  logic       ACTIVE;

  modport master (
    output CE, LD, DE, D_PIX, D_ATTR, BORDER, BLANK, FRAME,
    input  COL_R, COL_G, COL_B, COL_I, ACTIVE
  );

  modport slave (
    input  CE, LD, DE, D_PIX, D_ATTR, BORDER, BLANK, FRAME,
    output COL_R, COL_G, COL_B, COL_I, ACTIVE
  );
endinterface

// File: rtl/zx_pixel_serializer.sv
// ZX Spectrum pixel serializer: shifts one pixel byte per cell MSB first and applies
// ink/paper/bright/border/blank rules. Flash logic exists only with ZX_PIX_FLASH_EN defined.
module zx_pixel_serializer #(
  parameter int FLASH_DIV = 16
) (
  input logic                  C,
  input logic                  R,
  zx_pixel_serializer_if.slave bus
);
  logic [7:0] shift;
  logic [7:0] attr;
  logic [3:0] cnt;
  logic       act;
  logic       phase;
  logic       pix;
  logic [2:0] colour;
  logic       intensity;
  logic       active_next;

`ifdef ZX_PIX_FLASH_EN
  localparam int CW = $clog2(FLASH_DIV);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_DIV - 1);
  logic [CW-1:0] flash_cnt;

  // FRAME advances the flash phase independently of the pixel clock enable.
  always_ff @(posedge C) begin
    if (R) begin
      flash_cnt <= '0;
      phase     <= 1'b0;
    end else if (bus.FRAME) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt <= '0;
        phase     <= ~phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  assign pix = shift[7] ^ (attr[7] & phase);
`else
  logic unused_flash;
  assign phase        = 1'b0;
  assign pix          = shift[7];
  assign unused_flash = ^{bus.FRAME, attr[7], phase, FLASH_DIV < 2};
`endif

  // Colour choice is made from the state before this CE cycle's load/shift.
  always_comb begin
    colour      = bus.BORDER;
    intensity   = 1'b0;
    active_next = 1'b0;
    if (act) begin
      colour      = pix ? attr[2:0] : attr[5:3];
      intensity   = attr[6];
      active_next = 1'b1;
    end
    if (bus.BLANK) begin
      colour      = 3'b000;
      intensity   = 1'b0;
      active_next = 1'b0;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      shift      <= 8'h00;
      attr       <= 8'h00;
      cnt        <= 4'd0;
      act        <= 1'b0;
      bus.COL_G  <= 1'b0;
      bus.COL_R  <= 1'b0;
      bus.COL_B  <= 1'b0;
      bus.COL_I  <= 1'b0;
      bus.ACTIVE <= 1'b0;
    end else if (bus.CE) begin
      bus.COL_G  <= colour[2];
      bus.COL_R  <= colour[1];
      bus.COL_B  <= colour[0];
      bus.COL_I  <= intensity;
      bus.ACTIVE <= active_next;
      if (bus.LD) begin
        shift <= bus.D_PIX;
        attr  <= bus.D_ATTR;
        act   <= bus.DE;
        cnt   <= 4'd8;
      end else if (cnt != 4'd0) begin
        shift <= {shift[6:0], 1'b0};
        cnt   <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          act <= 1'b0;
        end
      end
    end
  end
endmodule
